// File: rtl/bsg_store_and_forward_pkt.sv
// rtl/bsg_store_and_forward_pkt.sv - packet store-and-forward buffer with commit/rollback and drop checks
// Optional saturating packet counters: define BSG_STORE_AND_FORWARD_PKT_COUNTERS_EN.
module bsg_store_and_forward_pkt #(
   parameter int width_p                 = 8,
   parameter int els_p                   = 8,
   parameter int write_no_backpressure_p = 0,
   parameter int drop_bad_p              = 0,
   parameter int max_len_p               = 0,
   parameter int count_width_p           = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [width_p-1:0]       data_i,
   input  logic                     v_i,
   input  logic                     last_i,
   input  logic                     error_i,
   output logic                     ready_o,
   output logic [width_p-1:0]       data_o,
   output logic                     v_o,
   output logic                     last_o,
   input  logic                     yumi_i,
   output logic                     good_packet_o,
   output logic                     incomplete_packet_o,
   output logic                     bad_packet_o,
   output logic [count_width_p-1:0] good_count_o,
   output logic [count_width_p-1:0] incomplete_count_o,
   output logic [count_width_p-1:0] bad_count_o
);
   localparam int addr_w = $clog2(els_p);
   localparam int ptr_w  = addr_w + 1;
   localparam int len_w  = (max_len_p > 0) ? $clog2(max_len_p + 1) : 1;

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

   state_e             state_r;
   logic [ptr_w-1:0]   wr_ptr_r, cmt_ptr_r, rd_ptr_r;
   logic               err_r;
   logic [len_w-1:0]   len_r;
   logic [width_p:0]   mem_r [els_p];

   logic full, overflow, enq, len_hit, drop_beat, err_any;

   // Top pointer bit distinguishes a full buffer from an empty one.
   assign full      = (wr_ptr_r - rd_ptr_r) == ptr_w'(els_p);
   assign overflow  = full && (cmt_ptr_r == rd_ptr_r);
   assign ready_o   = (write_no_backpressure_p != 0) || (state_r == DROP) || overflow || !full;
   assign enq       = v_i && ready_o;
   assign len_hit   = (max_len_p != 0) && (len_r == len_w'(max_len_p));
   assign drop_beat = (full && (write_no_backpressure_p != 0)) || overflow || len_hit;
   assign err_any   = err_r || error_i;

   assign v_o              = (rd_ptr_r != cmt_ptr_r);
   assign {last_o, data_o} = mem_r[rd_ptr_r[addr_w-1:0]];

   always_ff @(posedge clk_i)
      if (enq && (state_r != DROP) && !drop_beat)
         mem_r[wr_ptr_r[addr_w-1:0]] <= {last_i, data_i};

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r             <= IDLE;
         wr_ptr_r            <= '0;
         cmt_ptr_r           <= '0;
         rd_ptr_r            <= '0;
         err_r               <= 1'b0;
         len_r               <= '0;
         good_packet_o       <= 1'b0;
         incomplete_packet_o <= 1'b0;
         bad_packet_o        <= 1'b0;
      end else begin
         good_packet_o       <= 1'b0;
         incomplete_packet_o <= 1'b0;
         bad_packet_o        <= 1'b0;
         if (yumi_i)
            rd_ptr_r <= rd_ptr_r + 1'b1;
         if (enq) begin
            if (last_i) begin
               err_r   <= 1'b0;
               len_r   <= '0;
               state_r <= IDLE;
               if ((state_r == DROP) || drop_beat) begin
                  wr_ptr_r            <= cmt_ptr_r;
                  incomplete_packet_o <= 1'b1;
               end else if ((drop_bad_p != 0) && err_any) begin
                  wr_ptr_r     <= cmt_ptr_r;
                  bad_packet_o <= 1'b1;
               end else begin
                  // Commit: the packet becomes visible with its last beat.
                  wr_ptr_r      <= wr_ptr_r + 1'b1;
                  cmt_ptr_r     <= wr_ptr_r + 1'b1;
                  good_packet_o <= !err_any;
                  bad_packet_o  <= err_any;
               end
            end else begin
               err_r <= err_any;
               if (!len_hit)
                  len_r <= len_r + 1'b1;
               if (state_r != DROP) begin
                  if (drop_beat) begin
                     wr_ptr_r <= cmt_ptr_r;
                     state_r  <= DROP;
                  end else begin
                     wr_ptr_r <= wr_ptr_r + 1'b1;
                     state_r  <= RECV;
                  end
               end
            end
         end
      end
   end

`ifdef BSG_STORE_AND_FORWARD_PKT_COUNTERS_EN
   logic [count_width_p-1:0] good_cnt_r, inc_cnt_r, bad_cnt_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         good_cnt_r <= '0;
         inc_cnt_r  <= '0;
         bad_cnt_r  <= '0;
      end else begin
         if (good_packet_o && !(&good_cnt_r))
            good_cnt_r <= good_cnt_r + 1'b1;
         if (incomplete_packet_o && !(&inc_cnt_r))
            inc_cnt_r <= inc_cnt_r + 1'b1;
         if (bad_packet_o && !(&bad_cnt_r))
            bad_cnt_r <= bad_cnt_r + 1'b1;
      end
   end

   assign good_count_o       = good_cnt_r;
   assign incomplete_count_o = inc_cnt_r;
   assign bad_count_o        = bad_cnt_r;
`else
   assign good_count_o       = '0;
   assign incomplete_count_o = '0;
   assign bad_count_o        = '0;
`endif

endmodule

// File: doc/bsg_store_and_forward_pkt.md
# bsg_store_and_forward_pkt

Packet-granular store-and-forward buffer with its own circular storage and three pointers: speculative write, committed, and read. A packet becomes visible downstream only after its last beat has been accepted and the packet has passed the drop checks. Beyond a basic store-and-forward stage, it adds any-beat error tracking, an optional drop-on-error mode, a maximum packet length check, and optional saturating packet counters. It sits between a link receiver (with or without back-pressure) and packet consumers.

## Interface
- width_p, none (required): payload width.
- els_p, none (required): storage depth in beats; must be a power of 2 and ≥2.
- write_no_backpressure_p, none (required): 1 = upstream ignores back-pressure and ready_o is held at 1.
- drop_bad_p, 0: 1 = packets with error_i seen on any beat are discarded rather than forwarded.
- max_len_p, 0: maximum beats per packet; 0 = no limit beyond storage.
- count_width_p, 16: width of each packet counter.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_i  in  width_p  incoming beat.
- v_i  in  1  beat valid.
- last_i  in  1  final beat of the packet.
- error_i  in  1  beat carries an error; sticky over the packet.
- ready_o  out  1  beat may be accepted.
- data_o  out  width_p  head beat.
- v_o  out  1  committed beat available.
- last_o  out  1  head beat is the final beat of its packet.
- yumi_i  in  1  consumer takes the head beat; legal only while v_o=1.
- good_packet_o, incomplete_packet_o, bad_packet_o  out  1 each  one-cycle status pulses.
- good_count_o, incomplete_count_o, bad_count_o  out  count_width_p each  saturating counters.

## Operation
- Storage holds els_p entries of {data, last}.
- Pointers wr_ptr, cmt_ptr and rd_ptr are each log2(els_p)+1 bits, with the top bit used for wrap detection.
- Pointer-derived conditions:
  - full = (wr_ptr − rd_ptr) == els_p.
  - overflow = full & (cmt_ptr == rd_ptr), i.e. one packet fills the whole buffer.
  - v_o = (rd_ptr != cmt_ptr).
- Accepted beat (enq) = v_i & ready_o.
- ready_o = write_no_backpressure_p | (state==DROP) | overflow | ~full.
- State machine:
  - IDLE: no packet in progress.
  - RECV: packet in progress.
  - DROP: discarding the rest of a packet.
- Per-packet registers:
  - err_r: OR of error_i over accepted beats.
  - len_r: count of accepted beats.
- An enq beat is a drop beat if any of the following holds:
  - (full & write_no_backpressure_p);
  - overflow;
  - (max_len_p != 0 & len_r == max_len_p).
- enq, no drop, not last: write the beat at wr_ptr, increment wr_ptr, go to RECV.
- enq drop beat, not last: set wr_ptr to cmt_ptr (rollback) and go to DROP. In DROP every beat is accepted and discarded.
- enq last beat, not in DROP, not a drop beat:
  - drop_bad_p & (err_r | error_i): rollback, pulse bad, go to IDLE.
  - otherwise: write the beat, then set cmt_ptr and wr_ptr to wr_ptr+1.
    - Pulse bad if (err_r | error_i), else pulse good.
    - Go to IDLE.
- enq last beat while in DROP, or last beat that is itself a drop beat: rollback, pulse incomplete, go to IDLE.
- Exactly one status pulse per packet. err_r and len_r clear on every last-beat acceptance.
- yumi_i increments rd_ptr. Commit and yumi in the same cycle are both applied.

## Timing
- Reset (asynchronous assert, synchronous release): all pointers 0, state IDLE, err_r=len_r=0, status pulses 0, counters 0. Consequently v_o=0 and ready_o=1.
- Read path is combinational from storage at rd_ptr; data_o/last_o are don't-care while v_o=0.
- Last beat accepted at edge t: v_o rises after t if the buffer was previously empty, and the status pulse is high for the cycle following t.
- A single-beat packet (v_i & last_i in IDLE) commits in one cycle.
- Pointer wrap is handled by the top bit. Arithmetic is modulo 2^(log2(els_p)+1).
- Reset asserted mid-packet discards all stored and partial data.

## Configuration
- BSG_STORE_AND_FORWARD_PKT_COUNTERS_EN:
  - Defined: each counter increments on its status pulse and saturates at all-ones.
  - Undefined: counters and their registers are omitted, and the count outputs are tied to 0.
- Status pulses are unaffected by the macro.

## Test plan
- els_p=8, 3-beat packet, no error, yumi_i held at 1 → v_o rises the cycle after the last beat, 3 beats out with last_o on the third, good pulse once, good_count_o=1.
- drop_bad_p=1, 4-beat packet with error_i on beat 2 → v_o stays 0, bad pulse once, wr_ptr returns to cmt_ptr. A following good packet comes out intact.
- drop_bad_p=0, same stimulus → all 4 beats forwarded, bad pulse once.
- write_no_backpressure_p=1, els_p=4, no yumi, 6-beat packet → ready_o stays 1, DROP entered on beat 5, incomplete pulse on the last beat, v_o stays 0.
- write_no_backpressure_p=0, els_p=4, 2-beat packet stored but not read, then a 3-beat packet → ready_o drops when full. Releasing one yumi lets the packet continue, and it completes with a good pulse.
- max_len_p=2, 3-beat packet → incomplete pulse; reset_n_i pulsed mid-packet → v_o=0, counters=0.
